// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_sequencer
// Description : Reset sequencer and lock supervisor for the system PLL.
//               Pulses the PLL reset, waits for a stable synchronized lock,
//               then releases the core reset. Restarts on loss of lock or
//               user request, and latches FAIL after repeated lock timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart_req,
  output logic       pll_rst,
  output logic       core_reset,
  output logic       ready,
  output logic       fail,
  output logic [1:0] retry_count
);

  // One shared counter, wide enough for the longest phase
  localparam int c_MAX_A   = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
  localparam int c_MAX_ALL = (c_MAX_A > LOCK_TIMEOUT) ? c_MAX_A : LOCK_TIMEOUT;
  localparam int c_CNT_W   = (c_MAX_ALL > 1) ? $clog2(c_MAX_ALL) : 1;

  localparam logic [c_CNT_W-1:0] c_PLL_RST_LAST = c_CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_STABLE_LAST  = c_CNT_W'(STABLE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE      = c_CNT_W'(1);
  localparam logic [1:0]         c_MAX_RETRY    = 2'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLLRST    = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [1:0]         r_retry;
  logic [1:0]         w_retry_nxt;
  logic               r_sync1;
  logic               r_locked_s;
  logic               r_pll_rst;
  logic               r_core_reset;
  logic               r_ready;
  logic               r_fail;
  logic               w_counting;

  // Two-flop synchronizer for the asynchronous PLL lock indication
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_locked_s <= 1'b0;
    end else begin
      r_sync1    <= pll_locked;
      r_locked_s <= r_sync1;
    end
  end

  // State, counter, retry count and registered outputs
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state      <= S_PLLRST;
      r_cnt        <= '0;
      r_retry      <= 2'd0;
      r_pll_rst    <= 1'b1;
      r_core_reset <= 1'b1;
      r_ready      <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_retry      <= w_retry_nxt;
      r_pll_rst    <= (w_state_nxt == S_PLLRST);
      r_core_reset <= (w_state_nxt != S_RUN);
      r_ready      <= (w_state_nxt == S_RUN);
      r_fail       <= (w_state_nxt == S_FAIL);
    end
  end

  // Next-state, counter and retry decode; restart request overrides events
  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry;
    w_cnt_nxt   = '0;
    w_counting  = 1'b0;
    case (r_state)
      S_PLLRST: begin
        w_counting = 1'b1;
        if (r_cnt == c_PLL_RST_LAST) w_state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        w_counting = 1'b1;
        if (r_locked_s) begin
          w_state_nxt = S_STABLE;
        end else if (r_cnt == c_TIMEOUT_LAST) begin
          if (r_retry == c_MAX_RETRY) begin
            w_state_nxt = S_FAIL;
          end else begin
            w_retry_nxt = r_retry + 2'd1;
            w_state_nxt = S_PLLRST;
          end
        end
      end
      S_STABLE: begin
        w_counting = 1'b1;
        if (!r_locked_s)                  w_state_nxt = S_WAIT_LOCK;
        else if (r_cnt == c_STABLE_LAST)  w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!r_locked_s) w_state_nxt = S_PLLRST;
      end
      S_FAIL: begin
        w_state_nxt = S_FAIL;
      end
      default: begin
        w_state_nxt = S_PLLRST;
      end
    endcase

    // A successful release starts a fresh retry series
    if (w_state_nxt == S_RUN) w_retry_nxt = 2'd0;

    if (restart_req) begin
      w_state_nxt = S_PLLRST;
      w_retry_nxt = 2'd0;
    end

    // Counter clears on every state change and on restart
    if (w_counting && !restart_req && (w_state_nxt == r_state))
      w_cnt_nxt = r_cnt + c_CNT_ONE;
  end

  assign pll_rst     = r_pll_rst;
  assign core_reset  = r_core_reset;
  assign ready       = r_ready;
  assign fail        = r_fail;
  assign retry_count = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_lock_sequencer
// Description : Directed self-checking bench for pll_lock_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_sequencer;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       restart_req;
  logic       pll_rst;
  logic       core_reset;
  logic       ready;
  logic       fail;
  logic [1:0] retry_count;

  int n_checks;
  int n_err;

  pll_lock_sequencer #(
    .PLL_RST_CYCLES (4),
    .STABLE_CYCLES  (8),
    .LOCK_TIMEOUT   (20),
    .MAX_RETRIES    (2)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .restart_req (restart_req),
    .pll_rst     (pll_rst),
    .core_reset  (core_reset),
    .ready       (ready),
    .fail        (fail),
    .retry_count (retry_count)
  );

  // 50 MHz reference clock
  initial refclk = 1'b0;
  always #10 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Directed stimulus
  initial begin
    int pulses;
    logic prev;
    int seen_ready;
    n_checks    = 0;
    n_err       = 0;
    rst         = 1'b1;
    pll_locked  = 1'b0;
    restart_req = 1'b0;

    // ---- 1. reset values and normal bring-up
    tick(); tick();
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_ready", ready, 0);
    chk("rst_fail", fail, 0);
    chk("rst_retry", retry_count, 0);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("t1_pll_rst_high", pll_rst, 1);
    end
    tick();
    chk("t1_pll_rst_fall", pll_rst, 0);
    for (int k = 1; k <= 5; k++) tick();
    pll_locked = 1'b1;
    for (int k = 1; k <= 10; k++) tick();
    chk("t1_ready_edge10", ready, 0);
    tick();
    chk("t1_ready_edge11", ready, 1);
    chk("t1_core_reset", core_reset, 0);
    chk("t1_retry", retry_count, 0);

    // ---- 2. lock bounce during STABLE
    restart_req = 1'b1;
    pll_locked  = 1'b0;
    tick();
    chk("t2_restart_pll_rst", pll_rst, 1);
    chk("t2_restart_ready", ready, 0);
    restart_req = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    chk("t2_wait_pll_rst", pll_rst, 0);
    pll_locked = 1'b1;
    seen_ready = 0;
    for (int k = 5; k <= 21; k++) begin
      tick();
      if (ready) seen_ready++;
      if (k == 8)  pll_locked = 1'b0;
      if (k == 11) pll_locked = 1'b1;
    end
    chk("t2_no_early_ready", seen_ready, 0);
    tick();
    chk("t2_ready_release", ready, 1);
    chk("t2_retry", retry_count, 0);

    // ---- 3. timeout retries into FAIL
    restart_req = 1'b1;
    pll_locked  = 1'b0;
    tick();
    chk("t3_q0_pll_rst", pll_rst, 1);
    restart_req = 1'b0;
    pulses = 1;
    prev   = pll_rst;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (pll_rst && !prev) pulses++;
      prev = pll_rst;
      if (k == 23) begin
        chk("t3_q23_retry", retry_count, 0);
        chk("t3_q23_pll_rst", pll_rst, 0);
      end
      if (k == 24) begin
        chk("t3_q24_pll_rst", pll_rst, 1);
        chk("t3_q24_retry", retry_count, 1);
      end
      if (k == 47) chk("t3_q47_retry", retry_count, 1);
      if (k == 48) begin
        chk("t3_q48_pll_rst", pll_rst, 1);
        chk("t3_q48_retry", retry_count, 2);
      end
      if (k == 71) chk("t3_q71_fail", fail, 0);
      if (k == 72) begin
        chk("t3_q72_fail", fail, 1);
        chk("t3_q72_pll_rst", pll_rst, 0);
        chk("t3_q72_core_reset", core_reset, 1);
        chk("t3_q72_retry", retry_count, 2);
      end
    end
    chk("t3_pulse_count", pulses, 3);
    chk("t3_fail_held", fail, 1);
    chk("t3_pll_rst_held", pll_rst, 0);

    // ---- 4. recovery from FAIL
    restart_req = 1'b1;
    tick();
    chk("t4_fail_clear", fail, 0);
    chk("t4_retry_clear", retry_count, 0);
    chk("t4_pll_rst", pll_rst, 1);
    restart_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("t4_pll_rst_high", pll_rst, 1);
    end
    tick();
    chk("t4_pll_rst_fall", pll_rst, 0);
    pll_locked = 1'b1;
    for (int k = 5; k <= 14; k++) tick();
    chk("t4_ready_f14", ready, 0);
    tick();
    chk("t4_ready_f15", ready, 1);
    chk("t4_core_reset", core_reset, 0);

    // ---- 5. loss of lock in RUN
    pll_locked = 1'b0;
    tick(); tick();
    chk("t5_ready_l2", ready, 1);
    tick();
    chk("t5_core_reset_l3", core_reset, 1);
    chk("t5_ready_l3", ready, 0);
    chk("t5_pll_rst_l3", pll_rst, 1);
    pll_locked = 1'b1;
    for (int k = 4; k <= 15; k++) tick();
    chk("t5_ready_l15", ready, 0);
    tick();
    chk("t5_ready_l16", ready, 1);
    chk("t5_retry", retry_count, 0);

    // ---- 6a. restart on the cycle STABLE completes
    restart_req = 1'b1;
    tick();
    restart_req = 1'b0;
    for (int k = 1; k <= 12; k++) tick();
    chk("t6_ready_m12", ready, 0);
    restart_req = 1'b1;
    tick();
    chk("t6_ready_m13", ready, 0);
    chk("t6_pll_rst_m13", pll_rst, 1);
    restart_req = 1'b0;

    // ---- 6b. reset while in WAIT_LOCK with a nonzero retry count
    pll_locked = 1'b0;
    for (int k = 14; k <= 41; k++) begin
      tick();
      if (k == 37) chk("t6_m37_retry", retry_count, 1);
      if (k == 41) begin
        chk("t6_m41_pll_rst", pll_rst, 0);
        chk("t6_m41_retry", retry_count, 1);
      end
    end
    rst = 1'b1;
    tick();
    chk("t6_rst_pll_rst", pll_rst, 1);
    chk("t6_rst_retry", retry_count, 0);
    chk("t6_rst_core_reset", core_reset, 1);
    chk("t6_rst_ready", ready, 0);
    chk("t6_rst_fail", fail, 0);
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
